// File: rtl/basic_counter_pkg.sv
// ---------------------------------------------------------------------------
// basic_counter_pkg
//   Shared definitions for the loadable counter/timer family.
//   - cnt_state_t : controller state encoding (IDLE/RUN/EXPIRED); the unused
//                   code 2'b11 is treated as IDLE by the users of this type.
//   - CNT_W       : default counter/preset width.
// ---------------------------------------------------------------------------
package basic_counter_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUN     = 2'b01,
    ST_EXPIRED = 2'b10
  } cnt_state_t;

endpackage : basic_counter_pkg

// File: rtl/down_timer_unit.sv
// ---------------------------------------------------------------------------
// down_timer_unit
//   Loadable, cascadable down-counter/timer. A preset is loaded and counted
//   down to zero. Stepping past zero is an underflow: it raises a one-cycle
//   registered borrow pulse, and then the preset is either reloaded
//   (auto-reload mode) or the timer parks in EXPIRED (one-shot mode).
//
//   Ports
//     i_clk     : clock, all state changes on the rising edge
//     i_mr_n    : master reset, asynchronous, active-low
//     i_load_n  : synchronous preset load, active-low (valid in any state)
//     i_en      : count enable, active-high
//     i_ci      : cascade input from an upstream stage, tie 1 if unused
//     i_reload  : underflow mode, 1 = auto-reload, 0 = one-shot
//     i_d       : preset value (W bits)
//     o_q       : current count (registered)
//     o_bo      : borrow-out, one-cycle pulse after each underflow edge
//     o_run     : high while counting
//     o_done    : high while a one-shot run has expired
// ---------------------------------------------------------------------------
module down_timer_unit
  import basic_counter_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         i_clk,
  input  logic         i_mr_n,
  input  logic         i_load_n,
  input  logic         i_en,
  input  logic         i_ci,
  input  logic         i_reload,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q,
  output logic         o_bo,
  output logic         o_run,
  output logic         o_done
);

  cnt_state_t   r_state;
  logic [W-1:0] r_q;
  logic [W-1:0] r_p;
  logic         r_bo;

  cnt_state_t   w_state_next;
  logic [W-1:0] w_q_next;
  logic [W-1:0] w_p_next;
  logic         w_bo_next;
  logic         w_step;

  // A step only happens while counting and both enables agree.
  assign w_step = (r_state == ST_RUN) && i_en && i_ci;

  always_comb begin
    w_state_next = r_state;
    w_q_next     = r_q;
    w_p_next     = r_p;
    w_bo_next    = 1'b0;

    if (!i_load_n) begin
      // Load beats a coincident underflow: no borrow, no reload of old P.
      w_q_next     = i_d;
      w_p_next     = i_d;
      w_state_next = ST_RUN;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_step) begin
            if (r_q != '0) begin
              w_q_next = r_q - W'(1);
            end else begin
              // Underflow is handled explicitly so Q never wraps to all-ones.
              w_bo_next = 1'b1;
              if (i_reload) begin
                w_q_next = r_p;
              end else begin
                w_q_next     = '0;
                w_state_next = ST_EXPIRED;
              end
            end
          end
        end
        ST_IDLE, ST_EXPIRED: begin
          // Steps are ignored; only a load or reset leaves these states.
        end
        default: begin
          // Unused encoding falls back to IDLE.
          w_state_next = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_mr_n) begin
    if (!i_mr_n) begin
      r_state <= ST_IDLE;
      r_q     <= '0;
      r_p     <= '0;
      r_bo    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_q     <= w_q_next;
      r_p     <= w_p_next;
      r_bo    <= w_bo_next;
    end
  end

  assign o_q    = r_q;
  assign o_bo   = r_bo;
  assign o_run  = (r_state == ST_RUN);
  assign o_done = (r_state == ST_EXPIRED);

endmodule : down_timer_unit

// File: tb/tb_down_timer_unit.sv
// ---------------------------------------------------------------------------
// tb_down_timer_unit
//   Self-checking bench for down_timer_unit. A 4-bit instance is driven with
//   directed sequences and random stimulus against a behavioural model; an
//   8-bit instance is checked against closed-form reload arithmetic.
// ---------------------------------------------------------------------------
module tb_down_timer_unit;

  logic       clk = 1'b0;
  logic       mr_n;
  logic       load_n, en, ci, reload;
  logic [3:0] d;
  logic [3:0] q;
  logic       bo, run, done;

  logic       load8_n, en8, ci8, reload8;
  logic [7:0] d8;
  logic [7:0] q8;
  logic       bo8, run8, done8;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model of the 4-bit timer (plain integers).
  int  m_q, m_p;
  bit  m_counting, m_expired, m_bo;

  always #5 clk = ~clk;

  down_timer_unit #(.W(4)) dut4 (
    .i_clk(clk), .i_mr_n(mr_n), .i_load_n(load_n), .i_en(en), .i_ci(ci),
    .i_reload(reload), .i_d(d), .o_q(q), .o_bo(bo), .o_run(run), .o_done(done)
  );

  down_timer_unit #(.W(8)) dut8 (
    .i_clk(clk), .i_mr_n(mr_n), .i_load_n(load8_n), .i_en(en8), .i_ci(ci8),
    .i_reload(reload8), .i_d(d8), .o_q(q8), .o_bo(bo8), .o_run(run8), .o_done(done8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q = 0; m_p = 0; m_counting = 0; m_expired = 0; m_bo = 0;
  endtask

  // What the timer should show after one clock with the given inputs.
  task automatic model_edge(input bit ld_n, input bit e, input bit c, input bit rl, input int dv);
    m_bo = 0;
    if (!ld_n) begin
      m_q = dv; m_p = dv; m_counting = 1; m_expired = 0;
    end else if (m_counting && e && c) begin
      if (m_q > 0) begin
        m_q = m_q - 1;
      end else begin
        m_bo = 1;
        if (rl) m_q = m_p;
        else begin m_q = 0; m_counting = 0; m_expired = 1; end
      end
    end
  endtask

  // One transaction on the 4-bit instance: drive, clock, compare.
  task automatic cyc(input bit ld_n, input bit e, input bit c, input bit rl, input int dv);
    @(negedge clk);
    load_n = ld_n; en = e; ci = c; reload = rl; d = 4'(dv);
    model_edge(ld_n, e, c, rl, dv);
    @(posedge clk);
    #1;
    $display("txn ld_n=%0b en=%0b ci=%0b rl=%0b d=%0d -> q=%0d bo=%0b run=%0b done=%0b",
             ld_n, e, c, rl, dv, q, bo, run, done);
    check("q",    32'(q),    32'(m_q));
    check("bo",   32'(bo),   32'(m_bo));
    check("run",  32'(run),  32'(m_counting));
    check("done", 32'(done), 32'(m_expired));
  endtask

  initial begin
    int pulses;
    mr_n = 1'b0; load_n = 1'b1; en = 1'b0; ci = 1'b0; reload = 1'b0; d = '0;
    load8_n = 1'b1; en8 = 1'b0; ci8 = 1'b0; reload8 = 1'b0; d8 = '0;
    model_reset();
    #12;
    check("rst_q",    32'(q),    32'd0);
    check("rst_bo",   32'(bo),   32'd0);
    check("rst_run",  32'(run),  32'd0);
    check("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    mr_n = 1'b1;

    // Steps in IDLE are ignored.
    cyc(1, 1, 1, 1, 0);

    // 1: asynchronous reset mid-count with Q=5.
    cyc(0, 0, 1, 1, 9);
    repeat (4) cyc(1, 1, 1, 1, 0);
    check("t1_pre_q", 32'(q), 32'd5);
    @(negedge clk);
    #2;
    mr_n = 1'b0;
    #1;
    model_reset();
    check("t1_q",    32'(q),    32'd0);
    check("t1_bo",   32'(bo),   32'd0);
    check("t1_run",  32'(run),  32'd0);
    check("t1_done", 32'(done), 32'd0);
    #1;
    mr_n = 1'b1;

    // 2: one-shot from 3.
    cyc(0, 1, 1, 0, 3);
    check("t2_q_load", 32'(q), 32'd3);
    pulses = 0;
    for (int i = 0; i < 14; i++) begin
      cyc(1, 1, 1, 0, 0);
      pulses += int'(bo);
    end
    check("t2_pulses", 32'(pulses), 32'd1);
    check("t2_done",   32'(done),   32'd1);

    // 3: auto-reload from 2 for 12 cycles -> 4 borrow pulses.
    cyc(0, 1, 1, 1, 2);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(1, 1, 1, 1, 0);
      pulses += int'(bo);
    end
    check("t3_pulses", 32'(pulses), 32'd4);

    // 4: only EN&CI together decrement.
    cyc(0, 0, 0, 1, 4);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 0, 1, 0);
      cyc(1, 0, 1, 1, 0);
    end
    check("t4_hold", 32'(q), 32'd4);
    cyc(1, 1, 1, 1, 0);
    check("t4_dec", 32'(q), 32'd3);

    // 5: load coincident with underflow wins.
    cyc(0, 1, 1, 1, 0);
    cyc(0, 1, 1, 1, 7);
    check("t5_q",   32'(q),   32'd7);
    check("t5_bo",  32'(bo),  32'd0);
    check("t5_run", 32'(run), 32'd1);

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      cyc(($urandom_range(0, 9) != 0), ($urandom_range(0, 4) != 0),
          ($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)),
          int'($urandom_range(0, 15)));
    end

    // 6: 8-bit reload from FF for 512 steps -> exactly 2 pulses.
    @(negedge clk);
    load8_n = 1'b0; d8 = 8'hFF; en8 = 1'b1; ci8 = 1'b1; reload8 = 1'b1;
    @(posedge clk);
    #1;
    check("t6_q_load", 32'(q8), 32'hFF);
    pulses = 0;
    @(negedge clk);
    load8_n = 1'b1;
    for (int k = 1; k <= 512; k++) begin
      @(posedge clk);
      #1;
      check("t6_q",  32'(q8),  32'((255 - k) & 255));
      check("t6_bo", 32'(bo8), 32'((k % 256) == 0));
      pulses += int'(bo8);
    end
    $display("txn w8 512 steps -> %0d borrow pulses", pulses);
    check("t6_pulses", 32'(pulses), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard stop so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout reached got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule : tb_down_timer_unit
